// File: rtl/and_share_arb.sv
// Round-robin arbiter that time-shares one external AND datapath between NUM_REQ requesters,
// returns each result tagged with its requester index and counts datapath mismatches.
module and_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int ERR_W   = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  output logic [DATA_W-1:0]         op_a,
  output logic [DATA_W-1:0]         op_b,
  input  logic [DATA_W-1:0]         op_c,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [ERR_W-1:0]          err_count,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t              state_q;
  logic [ID_W-1:0]     ptr_q;
  logic [ID_W-1:0]     id_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [DATA_W-1:0]   rsp_data_q;
  logic                rsp_err_q;
  logic [ERR_W-1:0]    err_q;
  logic                busy_q;

  logic [ID_W-1:0]     grant;
  logic                any_valid;
  logic                mismatch;

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] base, input int offs);
    return ID_W'((int'(base) + offs) % NUM_REQ);
  endfunction

  // Scan downward so the last hit is the requester closest to the pointer.
  always_comb begin
    // NOTE: every comb output gets a default first, so no path can leave it unassigned (no latch).
    grant     = '0;
    any_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr_q, k)]) begin
        grant     = rr_idx(ptr_q, k);
        any_valid = 1'b1;
      end
    end
  end

  // Gated by rst_n so the accept vector is also zero while reset is held.
  assign req_ready = (rst_n && (state_q == IDLE) && any_valid) ? (NUM_REQ'(1) << grant) : '0;
  assign mismatch  = (op_c != (op_a_q & op_b_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      err_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            op_a_q  <= req_a[int'(grant)*DATA_W +: DATA_W];
            op_b_q  <= req_b[int'(grant)*DATA_W +: DATA_W];
            id_q    <= grant;
            ptr_q   <= rr_idx(grant, 1);
            busy_q  <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          rsp_data_q  <= op_c;
          rsp_err_q   <= mismatch;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          if (mismatch && (err_q != '1)) begin
            err_q <= err_q + ERR_W'(1);
          end
          state_q <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_and_share_arb.sv
// Directed bench for and_share_arb: a default instance plus a 2-bit error-counter instance
// sharing the same requests, each with its own ideal-or-faulty AND datapath.
module tb_and_share_arb;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_a = '0;
  logic [NR*DW-1:0] req_b = '0;
  logic          rsp_ready = 1'b0;
  logic          fault = 1'b0;

  logic [NR-1:0] req_ready, req_ready2;
  logic [DW-1:0] op_a, op_b, op_c, op_a2, op_b2, op_c2;
  logic          rsp_valid, rsp_valid2, rsp_err, rsp_err2, busy, busy2;
  logic [IW-1:0] rsp_id, rsp_id2;
  logic [DW-1:0] rsp_data, rsp_data2;
  logic [15:0]   err_count;
  logic [1:0]    err_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign op_c  = fault ? (op_a | op_b) : (op_a & op_b);
  assign op_c2 = fault ? (op_a2 | op_b2) : (op_a2 & op_b2);

  and_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .ERR_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .err_count(err_count), .busy(busy)
  );

  and_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
    .req_a(req_a), .req_b(req_b), .op_a(op_a2), .op_b(op_b2), .op_c(op_c2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_data(rsp_data2),
    .rsp_err(rsp_err2), .err_count(err_count2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_op_a"}, 32'(op_a), 0);
    check({tag, "_op_b"}, 32'(op_b), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_id"}, 32'(rsp_id), 0);
    check({tag, "_rsp_data"}, 32'(rsp_data), 0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 0);
    check({tag, "_err_count"}, 32'(err_count), 0);
    check({tag, "_err_count_sat"}, 32'(err_count2), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // Hand-computed AND results for the round-robin lane table.
  logic [DW-1:0] rr_res [NR] = '{8'h81, 8'h0F, 8'h50, 8'h00};

  initial begin
    // Reset state
    #3;
    check_all_zero("reset");

    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    set_lane(0, 8'h81, 8'hFF);
    set_lane(1, 8'hFF, 8'h0F);
    set_lane(2, 8'h5A, 8'hF0);
    set_lane(3, 8'hC3, 8'h3C);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;

    // Round robin: grant order 0,1,2,3,0,1,2,3 with one grant every 3 cycles
    for (int k = 0; k < 8; k++) begin
      check($sformatf("rr%0d_req_ready", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      step();
      check($sformatf("rr%0d_issue_busy", k), 32'(busy), 1);
      step();
      check($sformatf("rr%0d_rsp_valid", k), 32'(rsp_valid), 1);
      check($sformatf("rr%0d_rsp_id", k), 32'(rsp_id), 32'(k % 4));
      check($sformatf("rr%0d_rsp_data", k), 32'(rsp_data), 32'(rr_res[k % 4]));
      step();
    end

    // Single op on requester 0
    req_valid = 4'b0001;
    set_lane(0, 8'hF0, 8'h3C);
    #1;
    check("single_req_ready", 32'(req_ready), 32'(4'b0001));
    check("single_idle_busy", 32'(busy), 0);
    step();
    req_valid = 4'b0000;
    check("single_op_a", 32'(op_a), 32'h F0);
    check("single_op_b", 32'(op_b), 32'h3C);
    check("single_issue_rsp_valid", 32'(rsp_valid), 0);
    check("single_issue_req_ready", 32'(req_ready), 0);
    step();
    check("single_rsp_valid", 32'(rsp_valid), 1);
    check("single_rsp_id", 32'(rsp_id), 0);
    check("single_rsp_data", 32'(rsp_data), 32'h30);
    check("single_rsp_err", 32'(rsp_err), 0);
    check("single_err_count", 32'(err_count), 0);
    step();
    check("single_done_rsp_valid", 32'(rsp_valid), 0);
    check("single_done_busy", 32'(busy), 0);

    // Backpressure on requester 2 (pointer is 1)
    set_lane(2, 8'hAA, 8'h0F);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    #1;
    check("bp_req_ready", 32'(req_ready), 32'(4'b0100));
    step();
    req_valid = 4'b1111;
    step();
    for (int k = 0; k < 10; k++) begin
      check($sformatf("bp%0d_rsp_valid", k), 32'(rsp_valid), 1);
      check($sformatf("bp%0d_rsp_id", k), 32'(rsp_id), 2);
      check($sformatf("bp%0d_rsp_data", k), 32'(rsp_data), 32'h0A);
      check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 0);
      check($sformatf("bp%0d_busy", k), 32'(busy), 1);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check("bp_release_rsp_valid", 32'(rsp_valid), 1);
    step();
    check("bp_done_rsp_valid", 32'(rsp_valid), 0);
    check("bp_done_busy", 32'(busy), 0);
    check("bp_next_req_ready", 32'(req_ready), 32'(4'b1000));
    req_valid = 4'b0000;

    // Faulty datapath (op_c = a|b): five faults on requester 0
    fault = 1'b1;
    set_lane(0, 8'h0F, 8'hF0);
    req_valid = 4'b0001;
    #1;
    check("fault_req_ready", 32'(req_ready), 32'(4'b0001));
    for (int n = 1; n <= 5; n++) begin
      step();
      check($sformatf("fault%0d_op_a", n), 32'(op_a), 32'h0F);
      check($sformatf("fault%0d_op_b", n), 32'(op_b), 32'hF0);
      step();
      check($sformatf("fault%0d_rsp_id", n), 32'(rsp_id), 0);
      check($sformatf("fault%0d_rsp_data", n), 32'(rsp_data), 32'hFF);
      check($sformatf("fault%0d_rsp_err", n), 32'(rsp_err), 1);
      check($sformatf("fault%0d_err_count", n), 32'(err_count), 32'(n));
      check($sformatf("fault%0d_err_count_sat", n), 32'(err_count2), (n > 3) ? 3 : 32'(n));
      step();
    end
    req_valid = 4'b0000;
    fault     = 1'b0;

    // Skip and pointer: pointer at 1, only requesters 3 and 0 valid
    set_lane(0, 8'h81, 8'hFF);
    set_lane(3, 8'hC3, 8'h3C);
    req_valid = 4'b1001;
    #1;
    check("skip_req_ready_first", 32'(req_ready), 32'(4'b1000));
    step();
    step();
    check("skip_rsp_id_first", 32'(rsp_id), 3);
    check("skip_rsp_data_first", 32'(rsp_data), 32'h00);
    check("skip_rsp_err_first", 32'(rsp_err), 0);
    step();
    check("skip_req_ready_second", 32'(req_ready), 32'(4'b0001));
    step();
    step();
    check("skip_rsp_id_second", 32'(rsp_id), 0);
    check("skip_rsp_data_second", 32'(rsp_data), 32'h81);
    step();
    req_valid = 4'b1111;
    #1;
    check("skip_pointer_after", 32'(req_ready), 32'(4'b0010));

    // Reset during ISSUE
    step();
    check("rst_in_issue_busy", 32'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    step();
    check("rst_held_rsp_valid", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", 32'(req_ready), 32'(4'b0001));
    step();
    check("rst_issue_rsp_valid", 32'(rsp_valid), 0);
    step();
    check("rst_rsp_valid", 32'(rsp_valid), 1);
    check("rst_rsp_id", 32'(rsp_id), 0);
    check("rst_rsp_data", 32'(rsp_data), 32'h81);
    check("rst_err_count", 32'(err_count), 0);
    step();
    req_valid = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
